xadc_drp_responder: RTL and testbench

Synthesizable responder for the XADC Dynamic Reconfiguration Port (DRP), emulating the XADC primitive's DRP side. It answers reads of the current-channel register (7'h14) and the voltage-channel register (7'h1c) with 12-bit samples left-justified in 16 bits. It also generates the XADC end-of-conversion and end-of-sequence pulses. It stands in for the XADC hard block in simulation and on boards without analog front-end, so the DRP initiator and its AXIS sample FIFO can be exercised end to end.

---
 rtl/xadc_drp_responder.sv | 135 +++++++++++++
 tb/tb_xadc_drp_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_responder.sv
// rtl/xadc_drp_responder.sv - XADC DRP-side stand-in: ramp/external samples, EOC/EOS pulses, latency-matched reads
module xadc_drp_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int READ_LATENCY = 4,
  parameter int CONVERSION_PERIOD = 26,
  parameter logic [11:0] CURRENT_STEP = 12'd1,
  parameter logic [11:0] VOLTAGE_STEP = 12'd3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  drp_den,
  input  logic                  drp_dwe,
  input  logic [ADDR_WIDTH-1:0] drp_daddr,
  input  logic [DATA_WIDTH-1:0] drp_di,
  output logic [DATA_WIDTH-1:0] drp_do,
  output logic                  drp_drdy,
  input  logic                  ext_override,
  input  logic [11:0]           ext_current,
  input  logic [11:0]           ext_voltage,
  output logic                  eoc_out,
  output logic                  eos_out,
  output logic [4:0]            channel_out,
  output logic                  drp_protocol_error
);

  localparam int CNT_W = (CONVERSION_PERIOD > 2) ? $clog2(CONVERSION_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONVERSION_PERIOD - 1);
  localparam logic CONV_CURRENT = 1'b0;
  localparam logic CONV_VOLTAGE = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CUR = ADDR_WIDTH'('h14);
  localparam logic [ADDR_WIDTH-1:0] ADDR_VOLT = ADDR_WIDTH'('h1c);
  localparam logic [4:0] CH_CUR = 5'h14;
  localparam logic [4:0] CH_VOLT = 5'h1c;
  localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

  logic [CNT_W-1:0]      conv_cnt;
  logic                  conv_state;
  logic [11:0]           cur_reg;
  logic [11:0]           volt_reg;
  logic                  busy;
  logic [3:0]            lat_cnt;
  logic [DATA_WIDTH-1:0] rdata_hold;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  conv_tc;
  logic                  accept;
  logic [11:0]           cur_next;
  logic [11:0]           volt_next;
  logic                  di_unused;

  assign di_unused = ^drp_di;
  assign conv_tc   = (conv_cnt == CONV_LAST);
  assign accept    = drp_den && !busy;
  assign cur_next  = ext_override ? ext_current : cur_reg + CURRENT_STEP;
  assign volt_next = ext_override ? ext_voltage : volt_reg + VOLTAGE_STEP;

  // Snapshot uses the current register contents, so a coincident update is not yet visible.
  always_comb begin
    rd_data = '0;
    if (!drp_dwe) begin
      if (drp_daddr == ADDR_CUR)
        rd_data = DATA_WIDTH'({cur_reg, 4'h0});
      else if (drp_daddr == ADDR_VOLT)
        rd_data = DATA_WIDTH'({volt_reg, 4'h0});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conv_cnt    <= '0;
      conv_state  <= CONV_CURRENT;
      cur_reg     <= '0;
      volt_reg    <= '0;
      eoc_out     <= 1'b0;
      eos_out     <= 1'b0;
      channel_out <= 5'h00;
    end else begin
      eoc_out <= 1'b0;
      eos_out <= 1'b0;
      if (conv_tc) begin
        conv_cnt <= '0;
        eoc_out  <= 1'b1;
        if (conv_state == CONV_CURRENT) begin
          cur_reg     <= cur_next;
          channel_out <= CH_CUR;
          conv_state  <= CONV_VOLTAGE;
        end else begin
          volt_reg    <= volt_next;
          channel_out <= CH_VOLT;
          eos_out     <= 1'b1;
          conv_state  <= CONV_CURRENT;
        end
      end else begin
        conv_cnt <= conv_cnt + 1'b1;
      end
    end
  end

  // busy drops in the same edge drdy rises, so a den coinciding with drdy is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy               <= 1'b0;
      lat_cnt            <= '0;
      rdata_hold         <= '0;
      drp_do             <= '0;
      drp_drdy           <= 1'b0;
      drp_protocol_error <= 1'b0;
    end else begin
      drp_drdy <= 1'b0;
      drp_do   <= '0;
      if (drp_den && busy)
        drp_protocol_error <= 1'b1;
      if (busy) begin
        if (lat_cnt == 4'd1) begin
          drp_drdy <= 1'b1;
          drp_do   <= rdata_hold;
          busy     <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end
      if (accept) begin
        if (READ_LATENCY == 1) begin
          drp_drdy <= 1'b1;
          drp_do   <= rd_data;
        end else begin
          busy       <= 1'b1;
          lat_cnt    <= LAT_LOAD;
          rdata_hold <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// tb/tb_xadc_drp_responder.sv - directed scoreboard bench for xadc_drp_responder
module tb_xadc_drp_responder;

  logic        clk;
  logic        reset_n;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        ext_override;
  logic [11:0] ext_current;
  logic [11:0] ext_voltage;
  logic        eoc_out;
  logic        eos_out;
  logic [4:0]  channel_out;
  logic        drp_protocol_error;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int first_eoc = -1;
  int first_eos = -1;
  logic [15:0] sb[$];

  xadc_drp_responder dut (
    .clk(clk), .reset_n(reset_n), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy),
    .ext_override(ext_override), .ext_current(ext_current), .ext_voltage(ext_voltage),
    .eoc_out(eoc_out), .eos_out(eos_out), .channel_out(channel_out),
    .drp_protocol_error(drp_protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every drdy pops one expected word; drp_do must be 0 otherwise.
  always @(negedge clk) begin
    if (reset_n) begin
      if (eoc_out && first_eoc < 0) first_eoc = cyc;
      if (eos_out && first_eos < 0) first_eos = cyc;
      if (drp_drdy) begin
        if (sb.size() == 0) check("unexpected_drdy", {15'd0, drp_drdy}, 16'd0);
        else check("drp_do", drp_do, sb.pop_front());
      end else begin
        check("drp_do_idle", drp_do, 16'h0000);
      end
    end
  end

  // Called at a negedge; leaves the bench at the negedge where drdy is seen.
  task automatic txn(input logic [6:0] addr, input logic we, input logic [15:0] di,
                     input logic [15:0] exp);
    int n;
    drp_den = 1'b1; drp_daddr = addr; drp_dwe = we; drp_di = di;
    sb.push_back(exp);
    @(negedge clk);
    drp_den = 1'b0; drp_dwe = 1'b0;
    n = 1;
    while (!drp_drdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 16'(n), 16'd4);
  endtask

  task automatic wait_eoc(input logic [4:0] ch);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(eoc_out && channel_out == ch) && n < 200);
    check("eoc_found", {15'd0, eoc_out}, 16'd1);
  endtask

  initial begin
    logic saw;
    reset_n = 1'b0; drp_den = 1'b0; drp_dwe = 1'b0; drp_daddr = '0; drp_di = '0;
    ext_override = 1'b0; ext_current = '0; ext_voltage = '0;
    repeat (3) @(negedge clk);
    check("rst_do", drp_do, 16'h0000);
    check("rst_drdy", {15'd0, drp_drdy}, 16'd0);
    check("rst_eoc", {15'd0, eoc_out}, 16'd0);
    check("rst_eos", {15'd0, eos_out}, 16'd0);
    check("rst_chan", {11'd0, channel_out}, 16'h0000);
    check("rst_err", {15'd0, drp_protocol_error}, 16'd0);

    reset_n = 1'b1;
    rel_cyc = cyc;
    txn(7'h14, 1'b0, 16'h0, 16'h0000);

    // Internal ramp: current 0+1, voltage 0+3
    wait_eoc(5'h14);
    check("eos_on_cur", {15'd0, eos_out}, 16'd0);
    txn(7'h14, 1'b0, 16'h0, 16'h0010);
    wait_eoc(5'h1c);
    check("eos_on_volt", {15'd0, eos_out}, 16'd1);
    txn(7'h1c, 1'b0, 16'h0, 16'h0030);
    check("first_eoc_time", 16'(first_eoc - rel_cyc), 16'd26);
    check("first_eos_time", 16'(first_eos - rel_cyc), 16'd52);

    // External override
    ext_override = 1'b1; ext_current = 12'hABC; ext_voltage = 12'h123;
    wait_eoc(5'h14);
    txn(7'h14, 1'b0, 16'h0, 16'hABC0);
    wait_eoc(5'h1c);
    check("eos_override", {15'd0, eos_out}, 16'd1);
    txn(7'h1c, 1'b0, 16'h0, 16'h1230);

    // den on the voltage update edge sees the pre-update value
    ext_voltage = 12'h456;
    wait_eoc(5'h14);
    repeat (25) @(negedge clk);
    txn(7'h1c, 1'b0, 16'h0, 16'h1230);
    txn(7'h1c, 1'b0, 16'h0, 16'h4560);

    // Ramp wrap: FFE + 3 = 001; current continues from ABC
    ext_voltage = 12'hFFE;
    wait_eoc(5'h1c);
    ext_override = 1'b0;
    wait_eoc(5'h1c);
    txn(7'h1c, 1'b0, 16'h0, 16'h0010);

    // Write is discarded, unmapped read is zero
    txn(7'h14, 1'b1, 16'h1234, 16'h0000);
    txn(7'h14, 1'b0, 16'h0, 16'hABD0);
    txn(7'h00, 1'b0, 16'h0, 16'h0000);

    // Protocol violation: second den ignored, no scoreboard entry
    wait_eoc(5'h14);
    drp_den = 1'b1; drp_daddr = 7'h14; sb.push_back(16'hABE0);
    @(negedge clk); drp_den = 1'b0;
    check("err_before", {15'd0, drp_protocol_error}, 16'd0);
    @(negedge clk); drp_den = 1'b1; drp_daddr = 7'h1c;
    @(negedge clk); drp_den = 1'b0;
    check("err_set", {15'd0, drp_protocol_error}, 16'd1);
    check("no_early_drdy", {15'd0, drp_drdy}, 16'd0);
    @(negedge clk);
    check("drdy_cycle4", {15'd0, drp_drdy}, 16'd1);
    txn(7'h14, 1'b0, 16'h0, 16'hABE0);
    check("err_sticky", {15'd0, drp_protocol_error}, 16'd1);

    // Reset mid-transaction
    @(negedge clk);
    drp_den = 1'b1; drp_daddr = 7'h14;
    @(negedge clk); drp_den = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("mid_rst_do", drp_do, 16'h0000);
    check("mid_rst_drdy", {15'd0, drp_drdy}, 16'd0);
    check("mid_rst_eoc", {15'd0, eoc_out | eos_out}, 16'd0);
    check("mid_rst_chan", {11'd0, channel_out}, 16'h0000);
    check("mid_rst_err", {15'd0, drp_protocol_error}, 16'd0);
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw = saw | drp_drdy;
    end
    check("no_drdy_after_rst", {15'd0, saw}, 16'd0);
    txn(7'h14, 1'b0, 16'h0, 16'h0000);
    txn(7'h1c, 1'b0, 16'h0, 16'h0000);
    @(negedge clk);
    check("sb_drained", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
